// File: rtl/abr_params_pkg.sv
// Shared parameters and types for the masked A2B/B2A converters.
// ABR_B2A_OUT_REFRESH_EN adds one output refresh stage to the B2A latency.
package abr_params_pkg;

  typedef logic [1:0] share_t;

`ifdef ABR_B2A_OUT_REFRESH_EN
  localparam int ABR_B2A_REFRESH_STAGES = 1;
`else
  localparam int ABR_B2A_REFRESH_STAGES = 0;
`endif

  localparam int ABR_B2A_WIDTH   = 8;
  localparam int ABR_B2A_LATENCY = ABR_B2A_WIDTH + 2 + ABR_B2A_REFRESH_STAGES;

  function automatic int abr_b2a_latency(input int width);
    return width + 2 + ABR_B2A_REFRESH_STAGES;
  endfunction

endpackage

// File: rtl/abr_masked_full_adder.sv
// One-bit masked full adder on 2-share Boolean operands, registered outputs.
// Carry uses maj(x,y,c) = x ^ ((x^y) & (x^c)) with a single masked AND.
module abr_masked_full_adder
  import abr_params_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   zeroize,
  input  share_t x,
  input  share_t y,
  input  share_t c_in,
  input  logic   rnd,
  output share_t s,
  output share_t c_out
);

  share_t a, b;
  logic   z0, z1;
  share_t s_d, s_q, c_d, c_q;

  always_comb begin
    a   = x ^ y;
    b   = x ^ c_in;
    // Cross terms are re-masked by the same fresh bit in both shares.
    z0  = (a[0] & b[0]) ^ (a[0] & b[1]) ^ rnd;
    z1  = (a[1] & b[1]) ^ (a[1] & b[0]) ^ rnd;
    s_d = x ^ y ^ c_in;
    c_d = {x[1] ^ z1, x[0] ^ z0};
    if (zeroize) begin
      s_d = '0;
      c_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      c_q <= '0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign s     = s_q;
  assign c_out = c_q;

endmodule

// File: rtl/abr_masked_b2a_conv.sv
// Boolean-to-arithmetic 2-share converter: a_share0 = x - r, a_share1 = r.
// Optional ABR_B2A_OUT_REFRESH_EN adds a final additive share refresh stage.
module abr_masked_b2a_conv
  import abr_params_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             zeroize,
  input  logic             valid_i,
  input  share_t           x [WIDTH-1:0],
  input  logic [WIDTH-1:0] rnd_arith,
  input  logic [WIDTH-1:0] rnd_mask,
  input  logic [WIDTH-1:0] rnd_and,
`ifdef ABR_B2A_OUT_REFRESH_EN
  input  logic [WIDTH-1:0] rnd_refresh,
`endif
  output logic             valid_o,
  output logic [WIDTH-1:0] a_share0,
  output logic [WIDTH-1:0] a_share1
);

  localparam int LB = WIDTH + 2;
  localparam int L  = abr_b2a_latency(WIDTH);

  logic [WIDTH:0][1:0]   carry;
  logic [WIDTH-1:0][1:0] s_raw;
  logic [WIDTH-1:0][1:0] s_al;

  assign carry[0] = 2'b01;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    share_t xs_d [0:i];
    share_t xs_q [0:i];
    share_t ys_d [0:i];
    share_t ys_q [0:i];

    // Index 0 is the capture stage; bit i waits i more cycles for its carry.
    always_comb begin
      xs_d[0] = x[i];
      ys_d[0] = {rnd_mask[i], ~rnd_arith[i] ^ rnd_mask[i]};
      for (int k = 1; k <= i; k++) begin
        xs_d[k] = xs_q[k-1];
        ys_d[k] = ys_q[k-1];
      end
      if (zeroize) begin
        for (int k = 0; k <= i; k++) begin
          xs_d[k] = '0;
          ys_d[k] = '0;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= i; k++) begin
          xs_q[k] <= '0;
          ys_q[k] <= '0;
        end
      end else begin
        for (int k = 0; k <= i; k++) begin
          xs_q[k] <= xs_d[k];
          ys_q[k] <= ys_d[k];
        end
      end
    end

    abr_masked_full_adder u_fa (
      .clk     (clk),
      .rst_n   (rst_n),
      .zeroize (zeroize),
      .x       (xs_q[i]),
      .y       (ys_q[i]),
      .c_in    (carry[i]),
      .rnd     (rnd_and[i]),
      .s       (s_raw[i]),
      .c_out   (carry[i+1])
    );

    localparam int D = WIDTH - 1 - i;
    if (D == 0) begin : g_nodeskew
      assign s_al[i] = s_raw[i];
    end else begin : g_deskew
      share_t ds_d [0:D-1];
      share_t ds_q [0:D-1];

      always_comb begin
        ds_d[0] = s_raw[i];
        for (int k = 1; k < D; k++) ds_d[k] = ds_q[k-1];
        if (zeroize) begin
          for (int k = 0; k < D; k++) ds_d[k] = '0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) ds_q[k] <= '0;
        end else begin
          for (int k = 0; k < D; k++) ds_q[k] <= ds_d[k];
        end
      end

      assign s_al[i] = ds_q[D-1];
    end
  end

  logic [WIDTH-1:0] r_d [0:LB-2];
  logic [WIDTH-1:0] r_q [0:LB-2];
  logic [L-1:0]     vld_d, vld_q;
  logic [WIDTH-1:0] a0_d, a0_q, a1_d, a1_q;

  // The only place the Boolean shares recombine; x - r is uniform here.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) a0_d[i] = s_al[i][0] ^ s_al[i][1];
    r_d[0] = rnd_arith;
    for (int k = 1; k <= LB - 2; k++) r_d[k] = r_q[k-1];
    a1_d  = r_q[LB-2];
    vld_d = {vld_q[L-2:0], valid_i};
    if (zeroize) begin
      a0_d  = '0;
      a1_d  = '0;
      vld_d = '0;
      for (int k = 0; k <= LB - 2; k++) r_d[k] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q  <= '0;
      a1_q  <= '0;
      vld_q <= '0;
      for (int k = 0; k <= LB - 2; k++) r_q[k] <= '0;
    end else begin
      a0_q  <= a0_d;
      a1_q  <= a1_d;
      vld_q <= vld_d;
      for (int k = 0; k <= LB - 2; k++) r_q[k] <= r_d[k];
    end
  end

  assign valid_o = vld_q[L-1];

`ifdef ABR_B2A_OUT_REFRESH_EN
  logic [WIDTH-1:0] ref0_d, ref0_q, ref1_d, ref1_q;

  always_comb begin
    ref0_d = a0_q + rnd_refresh;
    ref1_d = a1_q - rnd_refresh;
    if (zeroize) begin
      ref0_d = '0;
      ref1_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref0_q <= '0;
      ref1_q <= '0;
    end else begin
      ref0_q <= ref0_d;
      ref1_q <= ref1_d;
    end
  end

  assign a_share0 = ref0_q;
  assign a_share1 = ref1_q;
`else
  assign a_share0 = a0_q;
  assign a_share1 = a1_q;
`endif

endmodule

// File: tb/tb_abr_masked_b2a_conv.sv
// Self-checking bench for abr_masked_b2a_conv (WIDTH=8), cycle-indexed reference.
module tb_abr_masked_b2a_conv;

  localparam int W = 8;
`ifdef ABR_B2A_OUT_REFRESH_EN
  localparam int         L   = W + 3;
  localparam logic [7:0] REF = 8'h10;
`else
  localparam int         L   = W + 2;
  localparam logic [7:0] REF = 8'h00;
`endif

  logic         clk = 0;
  logic         rst_n;
  logic         zeroize;
  logic         valid_i;
  logic [1:0]   x_tb [W-1:0];
  logic [W-1:0] rnd_arith, rnd_mask, rnd_and;
`ifdef ABR_B2A_OUT_REFRESH_EN
  logic [W-1:0] rnd_refresh;
`endif
  logic         valid_o;
  logic [W-1:0] a_share0, a_share1;

  abr_masked_b2a_conv #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .zeroize   (zeroize),
    .valid_i   (valid_i),
    .x         (x_tb),
    .rnd_arith (rnd_arith),
    .rnd_mask  (rnd_mask),
    .rnd_and   (rnd_and),
`ifdef ABR_B2A_OUT_REFRESH_EN
    .rnd_refresh (rnd_refresh),
`endif
    .valid_o   (valid_o),
    .a_share0  (a_share0),
    .a_share1  (a_share1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected outputs indexed by the cycle at which they must be visible.
  bit         exp_v [4096];
  bit         exp_z [4096];
  logic [7:0] exp_a0 [4096];
  logic [7:0] exp_a1 [4096];
  logic [7:0] exp_x  [4096];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] r);
    valid_i = v;
    for (int i = 0; i < W; i++) x_tb[i] = {s1[i], s0[i]};
    rnd_arith = r;
    rnd_mask  = 8'($urandom);
    rnd_and   = 8'($urandom);
    if (v) begin
      exp_v[cyc+L]  = 1'b1;
      exp_x[cyc+L]  = s0 ^ s1;
      exp_a0[cyc+L] = (s0 ^ s1) - r + REF;
      exp_a1[cyc+L] = r - REF;
    end
  endtask

  task automatic tick();
    logic [7:0] sm;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("valid_o", 32'(valid_o), 32'(exp_v[cyc]));
    if (exp_v[cyc] || exp_z[cyc]) begin
      chk("a_share0", 32'(a_share0), exp_v[cyc] ? 32'(exp_a0[cyc]) : 32'h0);
      chk("a_share1", 32'(a_share1), exp_v[cyc] ? 32'(exp_a1[cyc]) : 32'h0);
    end
    if (exp_v[cyc]) begin
      sm = a_share0 + a_share1;
      chk("share_sum", 32'(sm), 32'(exp_x[cyc]));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
      tick();
    end
  endtask

  task automatic send_val(input logic [7:0] val, input logic [7:0] r);
    logic [7:0] m;
    m = 8'($urandom);
    drive(1'b1, m, m ^ val, r);
    tick();
  endtask

  initial begin
    int n0;
    rst_n   = 1'b0;
    zeroize = 1'b0;
`ifdef ABR_B2A_OUT_REFRESH_EN
    rnd_refresh = REF;
`endif
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    #23;
    chk("rst_valid_o", 32'(valid_o), 32'h0);
    chk("rst_a_share0", 32'(a_share0), 32'h0);
    chk("rst_a_share1", 32'(a_share1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Directed example and wrap-around cases.
    drive(1'b1, 8'h3C, 8'h99, 8'h17);
    tick();
    idle(L + 1);
    send_val(8'h00, 8'h01);
    send_val(8'hFF, 8'hFF);
    idle(L);

    // Same value and r under different sharings / gadget randomness.
    send_val(8'h5A, 8'h33);
    send_val(8'h5A, 8'h33);
    idle(L);

    // Bubble pattern 1,0,1,1,0.
    send_val(8'($urandom), 8'($urandom));
    idle(1);
    send_val(8'($urandom), 8'($urandom));
    send_val(8'($urandom), 8'($urandom));
    idle(L + 1);

    // 256 back-to-back conversions.
    for (int k = 0; k < 256; k++) send_val(8'($urandom), 8'($urandom));
    idle(L + 2);

    // Asynchronous reset in the middle of operation.
    for (int k = 0; k < 3; k++) send_val(8'($urandom), 8'($urandom));
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_o", 32'(valid_o), 32'h0);
    chk("midrst_a_share0", 32'(a_share0), 32'h0);
    chk("midrst_a_share1", 32'(a_share1), 32'h0);
    for (int k = cyc + 1; k <= cyc + L + 2; k++) exp_v[k] = 1'b0;
    exp_z[cyc+1] = 1'b1;
    exp_z[cyc+2] = 1'b1;
    idle(2);
    rst_n = 1'b1;
    send_val(8'hC3, 8'h4D);
    idle(L + 1);

    // Zeroize four cycles after a valid operand.
    n0 = cyc;
    send_val(8'($urandom), 8'($urandom));
    idle(3);
    zeroize = 1'b1;
    drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int k = cyc + 1; k <= cyc + L; k++) exp_v[k] = 1'b0;
    exp_z[cyc+1] = 1'b1;
    if (cyc != n0 + 4) chk("zeroize_offset", 32'(cyc), 32'(n0 + 4));
    tick();
    zeroize = 1'b0;
    idle(L + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/abr_masked_b2a_conv.md
Name: abr_masked_B2A_conv

Overview:
- Converts a WIDTH-bit value from Boolean 2-share masking to arithmetic 2-share masking mod 2^WIDTH.
- Output shares satisfy a_share0 + a_share1 = x0 ^ x1 (mod 2^WIDTH).
- Method:
  - a_share1 = r, where r is fresh randomness.
  - A masked ripple-carry adder computes Boolean shares of x + (~r) + 1, i.e. x - r.
  - The result is unmasked into a_share0. This is safe because x - r is uniform.
- Fully pipelined, one conversion per cycle. Sits beside the A2B converter in the masked sampler/decompose datapaths.

Parameters:
- WIDTH, 8, operand bit-width; arithmetic modulus is 2^WIDTH; legal range 2..32.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- zeroize  input  1  synchronous clear of all state.
- valid_i  input  1  operand valid, sampled every cycle.
- x  input  [1:0] x [WIDTH-1:0]  Boolean shares per bit; x[i][0] ^ x[i][1] is bit i of the value.
- rnd_arith  input  WIDTH  r; becomes a_share1.
- rnd_mask  input  WIDTH  mask used to Boolean-share ~r.
- rnd_and  input  WIDTH  per-bit gadget randomness, one bit per full-adder stage.
- valid_o  output  1  result valid.
- a_share0  output  WIDTH  arithmetic share 0 = x - r mod 2^WIDTH.
- a_share1  output  WIDTH  arithmetic share 1 = r.

Behaviour:
- Reset (rst_n low, async):
  - All pipeline registers clear.
  - valid_o = 0, a_share0 = 0, a_share1 = 0.
- zeroize (sync, highest priority after reset):
  - Same clear on the next edge.
  - In-flight operands are discarded and never produce valid_o.
- Datapath advances every cycle regardless of valid_i. valid_i travels a parallel shift register of depth L.
  - No backpressure; consumer must accept every valid_o.
- Latency L = WIDTH+2. valid_i at cycle t gives valid_o at cycle t+L. Bubbles are preserved in order.
- Stage 0 (capture) registers:
  - x shares.
  - ~r Boolean-shared as (~r ^ rnd_mask, rnd_mask).
  - r itself.
- Adder stages:
  - Bit i operands pass through a skew delay of i cycles before entering masked full adder i.
  - Carry into bit 0 is shares (1,0). Carry i+1 comes from adder i one cycle later.
  - Adder i uses rnd_and[i], sampled at the cycle bit i is processed.
  - Carry-out of bit WIDTH-1 is discarded, which gives the modular wrap.
- Sum bit i is de-skewed by WIDTH-1-i cycles so all bits align.
- Final stage: a_share0 <= s0 ^ s1. This is the only point where the shares recombine; it is a registered output.
- r delay line of depth L-1 feeds a_share1, aligned with a_share0.
- Outputs change only on clock edges. Values when valid_o=0 are don't-care except after reset/zeroize, where they are 0.
- Reset asserted mid-operation clears everything immediately. The first valid_o after release comes L cycles after the first new valid_i.

Optional Feature:
- Macro: ABR_B2A_OUT_REFRESH_EN.
- When defined:
  - Adds input rnd_refresh [WIDTH-1:0] and one extra output register stage.
  - a_share0' = a_share0 + rnd_refresh, a_share1' = a_share1 - rnd_refresh, both mod 2^WIDTH.
  - L = WIDTH+3; valid shift register is one deeper.
- When undefined: no rnd_refresh port, L = WIDTH+2, behaviour as above.

Decomposition:
- Shared package (abr_params_pkg): constant ABR_B2A_LATENCY = WIDTH+2, plus the +1 adjustment under the macro.
- Shared package: typedef for a 2-bit share pair, reused by A2B/B2A.
- Sub-module: reuse existing abr_masked_full_adder, one instance per bit.
  - Ports: 2-bit x, y, c_in shares; 1-bit rnd; registered 2-bit s and c_out; 1-cycle latency.
- No new sub-module; skew/de-skew registers stay in generate loops.

Test Plan:
- WIDTH=8; x shares (0x3C,0x99) (value 0xA5), r=0x17, valid_i one cycle -> 10 cycles later valid_o=1, a_share0=0x8E, a_share1=0x17.
- Wrap: value 0x00, r=0x01 -> a_share0=0xFF, a_share1=0x01. Value 0xFF, r=0xFF -> a_share0=0x00.
- Back-to-back: 256 consecutive valid_i with random x shares, r, rnd_mask, rnd_and -> valid_o high 256 consecutive cycles; each (a_share0 + a_share1) mod 256 equals x0^x1, in order.
- Bubble pattern valid_i=1,0,1,1,0 -> valid_o shows identical pattern shifted by L.
- Zeroize asserted 4 cycles after valid_i -> valid_o stays 0 for the remainder of the run; a_share0=a_share1=0 the cycle after zeroize.
- Same value and r with differing rnd_mask/rnd_and -> identical outputs. With ABR_B2A_OUT_REFRESH_EN and rnd_refresh=0x10 in the first scenario -> L=11, a_share0=0x9E, a_share1=0x07.
